uart_rx_oversampled: RTL and testbench

Parametrised UART receiver, successor to the fixed 16x/8N1-style receiver. Serial input passes through an input synchroniser. Each bit is decided by 3-sample majority vote. Start-bit glitches are rejected. Framing errors, line breaks and (optionally) parity errors are reported. Sits between the external rx pin and the frame/command parser, driven by the shared baud-rate sample_tick generator.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx_oversampled.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Signal bundle between the oversampled UART receiver, its sample-tick/pin side and the frame parser.
// The master modport is the receiver; the slave modport is the environment that drives it and consumes frames.
interface uart_rx_if #(
   parameter int DBITS = 8
);
   logic             sample_tick;
   logic             rx;
   logic [DBITS-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic             parity_err;
   logic             break_det;
   logic             busy;

   modport master (
      input  sample_tick, rx,
      output data_out, data_valid, frame_err, parity_err, break_det, busy
   );

   modport slave (
      output sample_tick, rx,
      input  data_out, data_valid, frame_err, parity_err, break_det, busy
   );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: synchronised rx, 3-sample majority vote per bit, glitch/framing/break detection.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and report parity_err.
module uart_rx_oversampled #(
   parameter int DBITS       = 8,
   parameter int SBITS       = 1,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input logic       i_clock,
   input logic       i_reset_n,
   uart_rx_if.master io_bus
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DBITS + 1);
   localparam int M  = OVERSAMPLE / 2;

   localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
   localparam logic [SW-1:0] S_MID  = SW'(M);
   localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_DLAST = NW'(DBITS - 1);
   localparam logic [NW-1:0] N_SLAST = NW'(SBITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
   } state_t;

   state_t             r_state, w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic               w_rx_s;
   logic [SW-1:0]      r_s_cnt, w_s_cnt_next;
   logic [NW-1:0]      r_n_cnt, w_n_cnt_next;
   logic [1:0]         r_samp, w_samp_next;
   logic [DBITS-1:0]   r_shift, w_shift_next;
   logic               r_ferr, w_ferr_next;
   logic               r_stop0, w_stop0_next;
   logic [DBITS-1:0]   r_data_out, w_data_out_next;
   logic               r_data_valid, w_data_valid_next;
   logic               r_frame_err, w_frame_err_next;
   logic               r_break_det, w_break_det_next;
   logic               w_vote;
   logic               w_brk;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bit, w_par_bit_next;
   logic               r_parity_err, w_parity_err_next;
`endif

   assign w_rx_s = r_sync[SYNC_STAGES-1];
   // r_samp[1] holds the M-1 sample, r_samp[0] the M sample; the M+1 sample is rx_s live.
   assign w_vote = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_rx_s) | (r_samp[0] & w_rx_s);

   always_comb begin
      w_state_next      = r_state;
      w_s_cnt_next      = r_s_cnt;
      w_n_cnt_next      = r_n_cnt;
      w_samp_next       = r_samp;
      w_shift_next      = r_shift;
      w_ferr_next       = r_ferr;
      w_stop0_next      = r_stop0;
      w_data_out_next   = r_data_out;
      w_data_valid_next = 1'b0;
      w_frame_err_next  = r_frame_err;
      w_break_det_next  = r_break_det;
      w_brk             = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bit_next    = r_par_bit;
      w_parity_err_next = r_parity_err;
`endif

      if (io_bus.sample_tick && r_state != IDLE && r_state != BREAK_WAIT) begin
         w_s_cnt_next = (r_s_cnt == S_LAST) ? '0 : r_s_cnt + 1'b1;
         if (r_s_cnt == S_PRE) w_samp_next[1] = w_rx_s;
         if (r_s_cnt == S_MID) w_samp_next[0] = w_rx_s;
      end

      case (r_state)
         IDLE: begin
            if (!w_rx_s) begin
               w_state_next = START;
               w_s_cnt_next = '0;
               w_ferr_next  = 1'b0;
            end
         end
         START: begin
            if (io_bus.sample_tick) begin
               if (r_s_cnt == S_VOTE && w_vote) begin
                  w_state_next = IDLE;
                  w_s_cnt_next = '0;
               end else if (r_s_cnt == S_LAST) begin
                  w_state_next = DATA;
                  w_n_cnt_next = '0;
                  w_s_cnt_next = '0;
               end
            end
         end
         DATA: begin
            if (io_bus.sample_tick) begin
               if (r_s_cnt == S_VOTE)
                  w_shift_next = {w_vote, r_shift[DBITS-1:1]};
               if (r_s_cnt == S_LAST) begin
                  w_s_cnt_next = '0;
                  if (r_n_cnt == N_DLAST) begin
                     w_n_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                     w_state_next = PARITY;
`else
                     w_state_next = STOP;
`endif
                  end else begin
                     w_n_cnt_next = r_n_cnt + 1'b1;
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (io_bus.sample_tick) begin
               if (r_s_cnt == S_VOTE)
                  w_par_bit_next = w_vote;
               if (r_s_cnt == S_LAST) begin
                  w_state_next = STOP;
                  w_n_cnt_next = '0;
                  w_s_cnt_next = '0;
               end
            end
         end
`endif
         STOP: begin
            if (io_bus.sample_tick) begin
               if (r_s_cnt == S_VOTE) begin
                  if (r_n_cnt == '0) w_stop0_next = w_vote;
                  if (!w_vote) w_ferr_next = 1'b1;
                  // Last stop bit finishes mid-bit so a back-to-back start edge is not missed.
                  if (r_n_cnt == N_SLAST) begin
                     w_brk = (r_shift == '0) && ((r_n_cnt == '0) ? !w_vote : !r_stop0);
`ifdef UART_RX_PARITY_EN
                     w_brk = w_brk && !r_par_bit;
                     w_parity_err_next = r_par_bit != ((^r_shift) ^ (PARITY_ODD != 0));
`endif
                     w_data_out_next   = r_shift;
                     w_data_valid_next = 1'b1;
                     w_frame_err_next  = r_ferr | !w_vote;
                     w_break_det_next  = w_brk;
                     w_state_next      = w_brk ? BREAK_WAIT : IDLE;
                     w_s_cnt_next      = '0;
                     w_n_cnt_next      = '0;
                  end
               end else if (r_s_cnt == S_LAST) begin
                  w_n_cnt_next = r_n_cnt + 1'b1;
                  w_s_cnt_next = '0;
               end
            end
         end
         BREAK_WAIT: begin
            if (w_rx_s) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state      <= IDLE;
         r_sync       <= '1;
         r_s_cnt      <= '0;
         r_n_cnt      <= '0;
         r_samp       <= '0;
         r_shift      <= '0;
         r_ferr       <= 1'b0;
         r_stop0      <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break_det  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_sync       <= {r_sync[SYNC_STAGES-2:0], io_bus.rx};
         r_s_cnt      <= w_s_cnt_next;
         r_n_cnt      <= w_n_cnt_next;
         r_samp       <= w_samp_next;
         r_shift      <= w_shift_next;
         r_ferr       <= w_ferr_next;
         r_stop0      <= w_stop0_next;
         r_data_out   <= w_data_out_next;
         r_data_valid <= w_data_valid_next;
         r_frame_err  <= w_frame_err_next;
         r_break_det  <= w_break_det_next;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= w_par_bit_next;
         r_parity_err <= w_parity_err_next;
`endif
      end
   end

   assign io_bus.data_out   = r_data_out;
   assign io_bus.data_valid = r_data_valid;
   assign io_bus.frame_err  = r_frame_err;
   assign io_bus.break_det  = r_break_det;
   assign io_bus.busy       = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
   assign io_bus.parity_err = r_parity_err;
`else
   assign io_bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8 data bits, 1 stop, 16x oversampling, a tick every 4 clocks.
// Define UART_RX_PARITY_EN for both RTL and bench to add the parity-bit frames and checks.
module tb_uart_rx_oversampled;
   localparam int BIT_CLKS = 64;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   uart_rx_if #(.DBITS(8)) bus ();

   uart_rx_oversampled #(
      .DBITS(8), .SBITS(1), .OVERSAMPLE(16), .SYNC_STAGES(2), .PARITY_ODD(0)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (reset_n),
      .io_bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      int tdiv;
      tdiv = 0;
      bus.sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         tdiv = (tdiv + 1) % 4;
         bus.sample_tick = (tdiv == 0);
      end
   end

   // Frame monitor: counts data_valid pulses and flags any pulse longer than one clock.
   int         vcount  = 0;
   int         dv_wide = 0;
   logic       dv_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.data_valid) vcount <= vcount + 1;
      if (bus.data_valid && dv_prev) dv_wide <= dv_wide + 1;
      dv_prev <= bus.data_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // A 1-bit with a one-tick low pulse in the middle of the bit time.
   task automatic send_glitch_one();
      bus.rx = 1'b1;
      repeat (32) @(negedge clk);
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx = 1'b1;
      repeat (BIT_CLKS - 36) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit && d[i]) send_glitch_one();
         else send_bit(d[i]);
      end
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) $display("note: parity argument unused");
`endif
      send_bit(stop);
   endtask

   task automatic check_frame(input string tag, input int v0, input logic [7:0] d,
                              input logic fe, input logic bd, input logic pe);
      check({tag, " valid_count"}, 32'(vcount - v0), 32'd1);
      check({tag, " data_out"},    32'(bus.data_out), 32'(d));
      check({tag, " frame_err"},   32'(bus.frame_err), 32'(fe));
      check({tag, " break_det"},   32'(bus.break_det), 32'(bd));
      check({tag, " parity_err"},  32'(bus.parity_err), 32'(pe));
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      logic [7:0] exp_data;
      logic       exp_fe;
      logic       exp_bd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int v0;
      logic [7:0] keep;

      vecs[0] = '{8'hA5, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 0, 8'h3C, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{8'h3C, 1'b0, 2, 8'h3C, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 2, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h81, 1'b1, 1, 8'h81, 1'b0, 1'b0};

      reset_n = 1'b0;
      bus.rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset busy",       32'(bus.busy), 32'd0);
      check("reset data_valid", 32'(bus.data_valid), 32'd0);
      check("reset data_out",   32'(bus.data_out), 32'd0);
      check("reset frame_err",  32'(bus.frame_err), 32'd0);
      check("reset break_det",  32'(bus.break_det), 32'd0);
      check("reset parity_err", 32'(bus.parity_err), 32'd0);
      reset_n = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);

      // Table: frames sent back-to-back unless a gap of idle bits follows.
      for (int k = 0; k < 7; k++) begin
         v0 = vcount;
         send_frame(vecs[k].data, ^vecs[k].data, vecs[k].stop, -1);
         for (int g = 0; g < vecs[k].gap; g++) send_bit(1'b1);
         check_frame($sformatf("vec%0d", k), v0, vecs[k].exp_data, vecs[k].exp_fe, vecs[k].exp_bd, 1'b0);
         check($sformatf("vec%0d busy", k), 32'(bus.busy), 32'd0);
         $display("vec%0d data=%02h stop=%0b -> data_out=%02h fe=%0b bd=%0b",
                  k, vecs[k].data, vecs[k].stop, bus.data_out, bus.frame_err, bus.break_det);
      end

      // Short start pulse is rejected as a glitch.
      v0 = vcount;
      keep = bus.data_out;
      bus.rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      check("glitch no_valid", 32'(vcount - v0), 32'd0);
      check("glitch busy",     32'(bus.busy), 32'd0);
      check("glitch data_out", 32'(bus.data_out), 32'(keep));
      $display("start glitch -> valid_count_delta=%0d busy=%0b", vcount - v0, bus.busy);

      // One-tick dip inside bit 3 is outvoted.
      v0 = vcount;
      send_frame(8'hFF, 1'b0, 1'b1, 3);
      send_bit(1'b1);
      check_frame("vote", v0, 8'hFF, 1'b0, 1'b0, 1'b0);
      $display("bit glitch 0xFF -> data_out=%02h fe=%0b", bus.data_out, bus.frame_err);

      // Long break, then a normal frame once the line recovers.
      v0 = vcount;
      bus.rx = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge clk);
      check_frame("break", v0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("break busy_waiting", 32'(bus.busy), 32'd1);
      $display("break -> data_out=%02h fe=%0b bd=%0b count=%0d", bus.data_out, bus.frame_err, bus.break_det, vcount - v0);
      send_bit(1'b1);
      send_bit(1'b1);
      v0 = vcount;
      send_frame(8'h55, 1'b0, 1'b1, -1);
      check_frame("after_break", v0, 8'h55, 1'b0, 1'b0, 1'b0);
      $display("after break 0x55 -> data_out=%02h fe=%0b bd=%0b", bus.data_out, bus.frame_err, bus.break_det);

`ifdef UART_RX_PARITY_EN
      v0 = vcount;
      send_frame(8'h07, 1'b0, 1'b1, -1);
      check_frame("parity_bad", v0, 8'h07, 1'b0, 1'b0, 1'b1);
      $display("0x07 parity=0 -> parity_err=%0b", bus.parity_err);
      v0 = vcount;
      send_frame(8'h07, 1'b1, 1'b1, -1);
      check_frame("parity_good", v0, 8'h07, 1'b0, 1'b0, 1'b0);
      $display("0x07 parity=1 -> parity_err=%0b", bus.parity_err);
`endif

      // Reset in the middle of the data bits drops the frame.
      v0 = vcount;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      bus.rx = 1'b0;
      repeat (30) @(negedge clk);
      check("middata busy_before", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("middata busy",       32'(bus.busy), 32'd0);
      check("middata data_out",   32'(bus.data_out), 32'd0);
      check("middata data_valid", 32'(bus.data_valid), 32'd0);
      check("middata frame_err",  32'(bus.frame_err), 32'd0);
      check("middata break_det",  32'(bus.break_det), 32'd0);
      check("middata parity_err", 32'(bus.parity_err), 32'd0);
      reset_n = 1'b1;
      bus.rx  = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("middata no_valid", 32'(vcount - v0), 32'd0);
      $display("mid-data reset -> busy=%0b valid_count_delta=%0d", bus.busy, vcount - v0);

      check("data_valid single_clock", 32'(dv_wide), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
